rally_sequencer: RTL and testbench



---
 rtl/tennis_pkg.sv | 36 +++
 rtl/rally_speed.sv | 31 +++
 rtl/rally_sequencer.sv | 156 +++++++++++++++
 tb/tb_rally_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tennis_pkg.sv
// Shared encodings and defaults for the LED tennis match controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package tennis_pkg;

  // Command to the 16-LED ball shifter
  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_SHL  = 2'b01,   // toward bit 15 (left end)
    CMD_SHR  = 2'b10,   // toward bit 0 (right end)
    CMD_LOAD = 2'b11
  } ball_cmd_e;

  // Match phases
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RALLY      = 2'd1,
    ST_POINT      = 2'd2,
    ST_MATCH_OVER = 2'd3
  } state_e;

  // Court ends: right player sits at bit 0, left player (or squash wall) at bit 15
  localparam logic [15:0] POS_RIGHT_END = 16'h0001;
  localparam logic [15:0] POS_LEFT_END  = 16'h8000;

  // Clock-divider speed defaults
  localparam logic [21:0] DEF_TOGGLE_INIT = 22'h35E100;
  localparam logic [21:0] DEF_TOGGLE_STEP = 22'h01FFFF;
  localparam logic [21:0] DEF_TOGGLE_MIN  = 22'h0F0000;

  // Score increment that saturates at the display limit of 99
  function automatic logic [6:0] score_inc(input logic [6:0] s);
    return (s >= 7'd99) ? 7'd99 : s + 7'd1;
  endfunction

endpackage

// File: rtl/rally_speed.sv
// Ball speed register: holds the divider toggle count, reloads on serve, speeds up on return.
// Latency: one newclock cycle from load/step to toggle_val.
// Backpressure: none; load/step are single-cycle strobes, load wins over step.
module rally_speed import tennis_pkg::*; #(
  parameter logic [21:0] TOGGLE_INIT = DEF_TOGGLE_INIT,
  parameter logic [21:0] TOGGLE_STEP = DEF_TOGGLE_STEP,
  parameter logic [21:0] TOGGLE_MIN  = DEF_TOGGLE_MIN
) (
  input  logic        newclock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [21:0] toggle_val
);

  // Compare in 23 bits so floor+step cannot wrap; below this the next step clamps to the floor
  localparam logic [22:0] FLOOR_PLUS_STEP = {1'b0, TOGGLE_MIN} + {1'b0, TOGGLE_STEP};

  // Speed register: reload to serve speed or subtract one step, never below the floor
  always_ff @(posedge newclock or posedge reset) begin
    if (reset) begin
      toggle_val <= TOGGLE_INIT;
    end else if (load) begin
      toggle_val <= TOGGLE_INIT;
    end else if (step) begin
      if ({1'b0, toggle_val} >= FLOOR_PLUS_STEP) toggle_val <= toggle_val - TOGGLE_STEP;
      else                                      toggle_val <= TOGGLE_MIN;
    end
  end

endmodule

// File: rtl/rally_sequencer.sv
// Match controller: drives the ball shifter, arbitrates buttons, keeps scores and ball speed.
// Latency: ball_cmd/serve_pos combinational; all other outputs registered (one cycle).
// Backpressure: none; buttons are levels sampled every game-clock edge.
module rally_sequencer import tennis_pkg::*; #(
  parameter int          MAX_SCORE   = 3,
  parameter int          MISS_LIMIT  = 3,
  parameter logic [21:0] TOGGLE_INIT = DEF_TOGGLE_INIT,
  parameter logic [21:0] TOGGLE_STEP = DEF_TOGGLE_STEP,
  parameter logic [21:0] TOGGLE_MIN  = DEF_TOGGLE_MIN
) (
  input  logic        newclock,
  input  logic        reset,
  input  logic        squash_mode,
  input  logic        left_hit,
  input  logic        right_hit,
  input  logic [15:0] ball_pos,
  output logic [1:0]  ball_cmd,
  output logic [15:0] serve_pos,
  output logic [21:0] toggle_val,
  output logic [6:0]  left_score,
  output logic [6:0]  right_score,
  output logic        score_upd,
  output logic        match_over,
  output logic        winner,
  output logic [2:0]  state_dbg
);

  localparam logic [6:0] MAX_SC   = 7'(MAX_SCORE);
  localparam logic [1:0] MISS_LIM = 2'(MISS_LIMIT);

  state_e     state;
  ball_cmd_e  cmd;
  logic       dir;      // 1 = ball travelling left (toward bit 15)
  logic       server;   // 1 = left player serves
  logic       mode;     // latched squash_mode for the whole match
  logic [1:0] miss;     // early presses by the receiver this flight
  logic       pt_left;  // 1 = the pending point goes to the left player

  logic       wall, recv_btn, server_btn, at_end, miss_out;
  logic       in_rally, do_serve, do_return, do_wall, lose_pt;
  logic [6:0] pt_score;

  // In squash the left end is the wall, so nobody presses for a leftward ball
  assign wall       = mode & dir;
  assign recv_btn   = wall ? 1'b0 : (dir ? left_hit : right_hit);
  assign server_btn = server ? left_hit : right_hit;
  assign at_end     = (ball_pos == (dir ? POS_LEFT_END : POS_RIGHT_END));
  assign miss_out   = (miss == MISS_LIM);
  assign in_rally   = (state == ST_RALLY);
  assign do_serve   = (state == ST_IDLE) && server_btn;
  assign do_return  = in_rally && at_end && recv_btn;
  assign do_wall    = in_rally && at_end && wall;
  // Point to the sender: receiver absent at its end, or too many early presses mid-flight
  assign lose_pt    = in_rally && (at_end ? (!wall && !recv_btn) : miss_out);
  assign pt_score   = score_inc(pt_left ? left_score : right_score);
  assign serve_pos  = server ? POS_LEFT_END : POS_RIGHT_END;
  assign ball_cmd   = cmd;
  assign state_dbg  = {1'b0, state};

  // Shifter command: load serve position while idle, move only while the ball is in flight
  always_comb begin
    cmd = CMD_HOLD;
    case (state)
      ST_IDLE:  cmd = CMD_LOAD;
      ST_RALLY: if (!at_end && !miss_out) cmd = dir ? CMD_SHL : CMD_SHR;
      default:  cmd = CMD_HOLD;
    endcase
  end

  rally_speed #(
    .TOGGLE_INIT (TOGGLE_INIT),
    .TOGGLE_STEP (TOGGLE_STEP),
    .TOGGLE_MIN  (TOGGLE_MIN)
  ) u_speed (
    .newclock   (newclock),
    .reset      (reset),
    .load       (do_serve),
    .step       (do_return),
    .toggle_val (toggle_val)
  );

  // Match FSM with scoring, early-press counting and registered status outputs
  always_ff @(posedge newclock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      dir         <= 1'b1;
      server      <= 1'b0;
      mode        <= 1'b0;
      miss        <= 2'd0;
      pt_left     <= 1'b0;
      left_score  <= 7'd0;
      right_score <= 7'd0;
      score_upd   <= 1'b0;
      match_over  <= 1'b0;
      winner      <= 1'b0;
    end else begin
      score_upd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_serve) begin
            state <= ST_RALLY;
            dir   <= ~server;
            mode  <= squash_mode;
            miss  <= 2'd0;
          end
        end
        ST_RALLY: begin
          if (do_wall || do_return) dir <= ~dir;
          if (do_return) begin
            miss <= 2'd0;
            if (mode) begin
              right_score <= score_inc(right_score);
              score_upd   <= 1'b1;
            end
          end else if (lose_pt) begin
            if (mode) begin
              // Squash ends on the first miss; the rally count is the result
              state      <= ST_MATCH_OVER;
              match_over <= 1'b1;
              winner     <= 1'b0;
            end else begin
              state   <= ST_POINT;
              pt_left <= ~dir;
            end
          end else if (!at_end && recv_btn && (miss != 2'd3)) begin
            miss <= miss + 2'd1;
          end
        end
        ST_POINT: begin
          if (pt_left) left_score  <= pt_score;
          else         right_score <= pt_score;
          score_upd <= 1'b1;
          server    <= ~pt_left;
          if (pt_score == MAX_SC) begin
            state      <= ST_MATCH_OVER;
            match_over <= 1'b1;
            winner     <= pt_left;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (left_hit || right_hit) begin
            left_score  <= 7'd0;
            right_score <= 7'd0;
            score_upd   <= 1'b1;
            match_over  <= 1'b0;
            miss        <= 2'd0;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rally_sequencer.sv
// Directed bench for rally_sequencer with a behavioural model of the 16-LED shifter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_rally_sequencer;

  logic        newclock;
  logic        reset;
  logic        squash_mode;
  logic        left_hit;
  logic        right_hit;
  logic [15:0] ball_pos;
  logic [1:0]  ball_cmd;
  logic [15:0] serve_pos;
  logic [21:0] toggle_val;
  logic [6:0]  left_score;
  logic [6:0]  right_score;
  logic        score_upd;
  logic        match_over;
  logic        winner;
  logic [2:0]  state_dbg;

  int nchk = 0;
  int nerr = 0;

  rally_sequencer dut (
    .newclock    (newclock),
    .reset       (reset),
    .squash_mode (squash_mode),
    .left_hit    (left_hit),
    .right_hit   (right_hit),
    .ball_pos    (ball_pos),
    .ball_cmd    (ball_cmd),
    .serve_pos   (serve_pos),
    .toggle_val  (toggle_val),
    .left_score  (left_score),
    .right_score (right_score),
    .score_upd   (score_upd),
    .match_over  (match_over),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  initial newclock = 1'b0;
  always #5 newclock = ~newclock;

  // Shifter model acting on the same edge as the controller
  always @(posedge newclock or posedge reset) begin
    if (reset) ball_pos <= 16'h0001;
    else begin
      case (ball_cmd)
        2'b01:   ball_pos <= ball_pos << 1;
        2'b10:   ball_pos <= ball_pos >> 1;
        2'b11:   ball_pos <= serve_pos;
        default: ball_pos <= ball_pos;
      endcase
    end
  end

  task automatic step();
    @(posedge newclock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance until the shifter model shows the ball at tgt, bounded
  task automatic run_to(input logic [15:0] tgt);
    int n;
    n = 0;
    while (ball_pos !== tgt && n < 40) begin
      step();
      n++;
    end
    chk("reach_pos", {16'h0, ball_pos}, {16'h0, tgt});
  endtask

  initial begin
    reset = 1'b1; squash_mode = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
    step(); step();

    // Reset state
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_cmd", ball_cmd, 2'b11);
    chk("rst_serve_pos", serve_pos, 16'h0001);
    chk("rst_toggle", toggle_val, 22'h35E100);
    chk("rst_lscore", left_score, 7'd0);
    chk("rst_rscore", right_score, 7'd0);
    chk("rst_upd", score_upd, 1'b0);
    chk("rst_mo", match_over, 1'b0);
    chk("rst_winner", winner, 1'b0);
    reset = 1'b0;

    // Tennis serve by right, 15 shift-left cycles, left returns on the 16th
    left_hit = 1'b1;                 // non-server button ignored in IDLE
    step();
    chk("idle_ignore_left", state_dbg, 3'd0);
    left_hit = 1'b0; right_hit = 1'b1;
    step();
    right_hit = 1'b0;
    chk("serve_state", state_dbg, 3'd1);
    for (int i = 0; i < 15; i++) begin
      chk("fly_shl", ball_cmd, 2'b01);
      step();
    end
    chk("at_left_end", ball_pos, 16'h8000);
    chk("end_hold", ball_cmd, 2'b00);
    left_hit = 1'b1; right_hit = 1'b1;   // both pressed: only receiver counts
    step();
    left_hit = 1'b0; right_hit = 1'b0;
    chk("ret1_toggle", toggle_val, 22'h33E101);
    chk("ret1_dir_shr", ball_cmd, 2'b10);
    run_to(16'h0001);
    right_hit = 1'b1;
    step();
    right_hit = 1'b0;
    chk("ret2_toggle", toggle_val, 22'h31E102);

    // Missed return by left
    run_to(16'h8000);
    chk("miss_hold", ball_cmd, 2'b00);
    step();
    chk("point_state", state_dbg, 3'd2);
    chk("point_rscore_old", right_score, 7'd0);
    step();
    chk("after_pt_state", state_dbg, 3'd0);
    chk("after_pt_rscore", right_score, 7'd1);
    chk("after_pt_upd", score_upd, 1'b1);
    chk("after_pt_serve", serve_pos, 16'h8000);
    step();
    chk("upd_pulse_end", score_upd, 1'b0);

    // Early presses by right (receiver) while ball flies from left
    left_hit = 1'b1;
    step();
    left_hit = 1'b0;
    step(); step(); step();
    right_hit = 1'b1;
    step(); step(); step();
    right_hit = 1'b0;
    chk("early_r_hold", ball_cmd, 2'b00);
    chk("early_r_state", state_dbg, 3'd1);
    step();
    chk("early_r_point", state_dbg, 3'd2);
    step();
    chk("early_r_lscore", left_score, 7'd1);
    chk("early_r_serve", serve_pos, 16'h0001);

    // Early presses by left while ball flies from right
    right_hit = 1'b1;
    step();
    right_hit = 1'b0;
    step(); step(); step();
    left_hit = 1'b1;
    step(); step(); step();
    left_hit = 1'b0;
    chk("early_l_hold", ball_cmd, 2'b00);
    chk("early_l_notend", (ball_pos == 16'h8000), 1'b0);
    step();
    chk("early_l_point", state_dbg, 3'd2);
    step();
    chk("early_l_rscore", right_score, 7'd2);

    // Next serve clears the early-press count; one press does not forfeit
    left_hit = 1'b1;
    step();
    left_hit = 1'b0;
    chk("miss_clr_cmd", ball_cmd, 2'b10);
    step(); step();
    right_hit = 1'b1;
    step();
    right_hit = 1'b0;
    step();
    chk("miss_clr_state", state_dbg, 3'd1);
    run_to(16'h0001);
    right_hit = 1'b1;
    step();
    right_hit = 1'b0;

    // Left misses: right reaches 3 and wins the match
    run_to(16'h8000);
    step();
    step();
    chk("mo_state", state_dbg, 3'd3);
    chk("mo_flag", match_over, 1'b1);
    chk("mo_winner", winner, 1'b0);
    chk("mo_rscore", right_score, 7'd3);
    chk("mo_upd", score_upd, 1'b1);
    chk("mo_cmd", ball_cmd, 2'b00);
    step();
    chk("mo_stay", state_dbg, 3'd3);
    left_hit = 1'b1;
    step();
    left_hit = 1'b0;
    chk("clr_state", state_dbg, 3'd0);
    chk("clr_lscore", left_score, 7'd0);
    chk("clr_rscore", right_score, 7'd0);
    chk("clr_mo", match_over, 1'b0);

    // Squash: left serves, mode latched then input dropped mid-match
    squash_mode = 1'b1;
    left_hit = 1'b1;
    step();
    left_hit = 1'b0; squash_mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      run_to(16'h0001);
      right_hit = 1'b1;
      step();
      right_hit = 1'b0;
      if (k == 0) begin
        chk("sq_upd", score_upd, 1'b1);
        chk("sq_rscore1", right_score, 7'd1);
      end
      if (k == 11) begin
        chk("sq_rscore12", right_score, 7'd12);
        chk("sq_toggle12", toggle_val, 22'h1DE10C);
      end
      if (k == 18) chk("sq_toggle19", toggle_val, 22'h0FE113);
      if (k == 19) begin
        chk("sq_toggle_min", toggle_val, 22'h0F0000);
        chk("sq_rscore20", right_score, 7'd20);
      end
      run_to(16'h8000);
      if (k == 0) begin
        chk("wall_hold", ball_cmd, 2'b00);
        step();
        chk("wall_return", ball_cmd, 2'b10);
        chk("wall_no_speed", toggle_val, 22'h33E101);
        chk("wall_state", state_dbg, 3'd1);
      end
    end
    run_to(16'h0001);
    chk("sq_miss_hold", ball_cmd, 2'b00);
    step();
    chk("sq_mo_state", state_dbg, 3'd3);
    chk("sq_mo_flag", match_over, 1'b1);
    chk("sq_winner", winner, 1'b0);
    chk("sq_final", right_score, 7'd20);
    right_hit = 1'b1;
    step();
    right_hit = 1'b0;
    chk("sq_clr", right_score, 7'd0);

    // Asynchronous reset mid-rally, between clock edges
    left_hit = 1'b1;
    step();
    left_hit = 1'b0;
    run_to(16'h0100);
    chk("pre_rst_state", state_dbg, 3'd1);
    chk("pre_rst_serve", serve_pos, 16'h8000);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", state_dbg, 3'd0);
    chk("arst_cmd", ball_cmd, 2'b11);
    chk("arst_serve", serve_pos, 16'h0001);
    chk("arst_toggle", toggle_val, 22'h35E100);
    chk("arst_upd", score_upd, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_idle", state_dbg, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
